// File: rtl/keypad_pkg.sv
// Shared keypad types: digit width, BCD digit type and entry FSM states.
// The keypad decoder and the lock/compare logic import the same package.
package keypad_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    SUBMIT = 2'd2
  } entry_state_t;

  // Bit positions of the four button/key event sources
  localparam int EV_KEY   = 0;
  localparam int EV_ENTER = 1;
  localparam int EV_BACK  = 2;
  localparam int EV_CLEAR = 3;
  localparam int NUM_EV   = 4;

  // Only decimal digits may enter the code register
  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= bcd_digit_t'(9));
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input. The history flop resets to 1 so a
// level that is already high when reset releases gives no pulse until it has
// been seen low at least once.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic pulse_o
);

  logic hist_q;

  // Track the previous level every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 1'b1;
    else     hist_q <= sig_i;
  end

  assign pulse_o = sig_i & ~hist_q;

endmodule

// File: rtl/digit_entry_buffer.sv
// Keypad digit entry buffer: turns key presses into a BCD code held in a
// shift register, supports backspace/clear, hands the finished code to the
// lock logic over valid/ready, and optionally drops a stale entry after an
// idle timeout.
module digit_entry_buffer
  import keypad_pkg::*;
#(
  parameter int unsigned MAX_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3:0]                         key_number,
  input  logic                               key_valid,
  input  logic                               enter_btn,
  input  logic                               back_btn,
  input  logic                               clear_btn,
  input  logic                               code_ready,
  output logic [DIGIT_W*MAX_DIGITS-1:0]      code_digits,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count,
  output logic                               code_valid,
  output logic                               overflow,
  output logic                               timeout
);

  localparam int CODE_W = DIGIT_W * MAX_DIGITS;
  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  entry_state_t      state_q, state_d;
  logic [CODE_W-1:0] digits_q, digits_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;

  logic [NUM_EV-1:0] btn_level;
  logic [NUM_EV-1:0] btn_pulse;
  logic              digit_press;
  logic              entry_event;
  logic              timer_last;

  assign btn_level = {clear_btn, back_btn, enter_btn, key_valid};

  generate
    for (genvar gi = 0; gi < NUM_EV; gi++) begin : g_edge
      rise_detect u_rise (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (btn_level[gi]),
        .pulse_o (btn_pulse[gi])
      );
    end
  endgenerate

  // A key press with a non-decimal number is dropped entirely
  assign digit_press = btn_pulse[EV_KEY] & is_bcd(key_number);
  assign entry_event = btn_pulse[EV_CLEAR] | btn_pulse[EV_ENTER] |
                       btn_pulse[EV_BACK]  | digit_press;

  // Next-state, shift register and pulse outputs; clear > enter > back > digit
  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (digit_press) begin
          digits_d = (digits_q << DIGIT_W) | CODE_W'(key_number);
          count_d  = count_q + CNT_ONE;
          state_d  = ENTRY;
        end
      end
      ENTRY: begin
        if (!entry_event) begin
          if (timer_last) begin
            digits_d  = '0;
            count_d   = '0;
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end else if (btn_pulse[EV_CLEAR]) begin
          digits_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end else if (btn_pulse[EV_ENTER]) begin
          state_d = SUBMIT;
        end else if (btn_pulse[EV_BACK]) begin
          digits_d = digits_q >> DIGIT_W;
          count_d  = count_q - CNT_ONE;
          if (count_q == CNT_ONE) state_d = IDLE;
        end else if (count_q == CNT_MAX) begin
          overflow_d = 1'b1;
        end else begin
          digits_d = (digits_q << DIGIT_W) | CODE_W'(key_number);
          count_d  = count_q + CNT_ONE;
        end
      end
      SUBMIT: begin
        // Code is frozen; only the consumer's ready moves us on
        if (code_ready) begin
          digits_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        digits_d = '0;
        count_d  = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // State, code register and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      digits_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timer
      localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
      logic [31:0] timer_q, timer_d;

      // Count only while sitting in ENTRY with nothing happening
      always_comb begin
        timer_d = '0;
        if (state_q == ENTRY && state_d == ENTRY && !entry_event)
          timer_d = timer_q + 32'd1;
      end

      // Inactivity timer register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
      end

      assign timer_last = (state_q == ENTRY) && (timer_q == TIMER_LAST);
    end else begin : g_no_timer
      assign timer_last = 1'b0;
    end
  endgenerate

  assign code_digits = digits_q;
  assign digit_count = count_q;
  assign code_valid  = (state_q == SUBMIT);
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Directed bench for digit_entry_buffer. Two instances share the stimulus:
// u_dut without timeout, u_dut_to with a 10-cycle idle timeout.
module tb_digit_entry_buffer;

  localparam logic [2:0] BTN_ENT  = 3'b001;
  localparam logic [2:0] BTN_BACK = 3'b010;
  localparam logic [2:0] BTN_CLR  = 3'b100;

  logic        clk;
  logic        rst;
  logic [3:0]  key_number;
  logic        key_valid;
  logic        enter_btn;
  logic        back_btn;
  logic        clear_btn;
  logic        code_ready;

  logic [15:0] digits_a, digits_b;
  logic [2:0]  count_a, count_b;
  logic        valid_a, valid_b;
  logic        ovf_a, ovf_b;
  logic        to_a, to_b;

  int n_cmp = 0;
  int n_bad = 0;
  int to_cnt = 0;
  int to_snap;
  logic ovf_seen;

  digit_entry_buffer #(.MAX_DIGITS(4), .TIMEOUT_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst), .key_number(key_number), .key_valid(key_valid),
    .enter_btn(enter_btn), .back_btn(back_btn), .clear_btn(clear_btn),
    .code_ready(code_ready), .code_digits(digits_a), .digit_count(count_a),
    .code_valid(valid_a), .overflow(ovf_a), .timeout(to_a)
  );

  digit_entry_buffer #(.MAX_DIGITS(4), .TIMEOUT_CYCLES(10)) u_dut_to (
    .clk(clk), .rst(rst), .key_number(key_number), .key_valid(key_valid),
    .enter_btn(enter_btn), .back_btn(back_btn), .clear_btn(clear_btn),
    .code_ready(code_ready), .code_digits(digits_b), .digit_count(count_b),
    .code_valid(valid_b), .overflow(ovf_b), .timeout(to_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count timeout pulses of the timeout instance
  always @(negedge clk) begin
    if (to_b === 1'b1) to_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One key press: high for one cycle, then released for one cycle
  task automatic press_key(input logic [3:0] d, output logic ovf);
    key_number = d;
    key_valid  = 1'b1;
    tick();
    ovf = ovf_a;
    key_valid = 1'b0;
    tick();
  endtask

  task automatic press_btn(input logic [2:0] m);
    {clear_btn, back_btn, enter_btn} = m;
    tick();
    {clear_btn, back_btn, enter_btn} = 3'b000;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    key_number = 4'd0;
    key_valid = 1'b0;
    enter_btn = 1'b0;
    back_btn = 1'b0;
    clear_btn = 1'b0;
    code_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_digits", 32'(digits_a), 32'h0);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_to", 32'(to_a), 32'd0);
    check("rst_to_b", 32'(to_b), 32'd0);
    check("rst_ovf_b", 32'(ovf_b), 32'd0);

    // 1,2,3,4 then enter; hold ready low, then transfer
    press_key(4'd1, ovf_seen);
    press_key(4'd2, ovf_seen);
    press_key(4'd3, ovf_seen);
    press_key(4'd4, ovf_seen);
    press_btn(BTN_ENT);
    check("sub_digits", 32'(digits_a), 32'h1234);
    check("sub_count", 32'(count_a), 32'd4);
    check("sub_valid", 32'(valid_a), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(valid_a), 32'd1);
      check("hold_digits", 32'(digits_a), 32'h1234);
    end
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    check("xfer_valid", 32'(valid_a), 32'd0);
    check("xfer_count", 32'(count_a), 32'd0);
    check("xfer_digits", 32'(digits_a), 32'h0);

    // Overflow on the fifth digit, then backspace
    press_key(4'd5, ovf_seen);
    press_key(4'd6, ovf_seen);
    press_key(4'd7, ovf_seen);
    press_key(4'd8, ovf_seen);
    check("full_ovf_quiet", 32'(ovf_seen), 32'd0);
    press_key(4'd9, ovf_seen);
    check("ovf_pulse", 32'(ovf_seen), 32'd1);
    check("ovf_after", 32'(ovf_a), 32'd0);
    check("ovf_digits", 32'(digits_a), 32'h5678);
    check("ovf_count", 32'(count_a), 32'd4);
    press_btn(BTN_BACK);
    check("back_digits", 32'(digits_a), 32'h0567);
    check("back_count", 32'(count_a), 32'd3);
    press_btn(BTN_CLR);
    check("clr_count", 32'(count_a), 32'd0);
    check("clr_digits", 32'(digits_a), 32'h0);

    // Held key with number change gives a single digit
    key_number = 4'd3;
    key_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    key_number = 4'd7;
    for (int i = 0; i < 15; i++) tick();
    check("held_digits", 32'(digits_a), 32'h0003);
    check("held_count", 32'(count_a), 32'd1);
    key_valid = 1'b0;
    tick();
    press_key(4'd7, ovf_seen);
    check("repress_digits", 32'(digits_a), 32'h0037);

    // Clear and enter together: clear wins, code never presented
    press_btn(BTN_CLR | BTN_ENT);
    check("ce_valid", 32'(valid_a), 32'd0);
    check("ce_count", 32'(count_a), 32'd0);
    press_btn(BTN_ENT);
    check("idle_ent_valid", 32'(valid_a), 32'd0);
    press_btn(BTN_BACK);
    check("idle_back_count", 32'(count_a), 32'd0);
    press_key(4'd12, ovf_seen);
    check("nonbcd_count", 32'(count_a), 32'd0);
    check("nonbcd_digits", 32'(digits_a), 32'h0);

    // Timeout instance: one digit, then 10 idle cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    press_key(4'd4, ovf_seen);
    for (int i = 0; i < 8; i++) tick();
    check("to_pre_count", 32'(count_b), 32'd1);
    check("to_pre_pulse", 32'(to_b), 32'd0);
    tick();
    check("to_pulse", 32'(to_b), 32'd1);
    check("to_count", 32'(count_b), 32'd0);
    check("to_digits", 32'(digits_b), 32'h0);
    check("to_valid", 32'(valid_b), 32'd0);
    tick();
    check("to_pulse_end", 32'(to_b), 32'd0);

    // Press landing on the expiry cycle keeps the entry alive
    to_snap = to_cnt;
    press_key(4'd4, ovf_seen);
    for (int i = 0; i < 8; i++) tick();
    press_key(4'd5, ovf_seen);
    #1;
    check("to_saved_count", 32'(count_b), 32'd2);
    check("to_saved_digits", 32'(digits_b), 32'h0045);
    check("to_no_pulse", 32'(to_cnt - to_snap), 32'd0);

    // Async reset in SUBMIT with a key held
    tick();
    press_btn(BTN_CLR);
    press_key(4'd2, ovf_seen);
    press_btn(BTN_ENT);
    check("r_sub_valid", 32'(valid_a), 32'd1);
    key_number = 4'd8;
    key_valid = 1'b1;
    tick();
    check("r_sub_ignore", 32'(count_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("r_async_valid", 32'(valid_a), 32'd0);
    check("r_async_count", 32'(count_a), 32'd0);
    check("r_async_digits", 32'(digits_a), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("r_held_count", 32'(count_a), 32'd0);
    key_valid = 1'b0;
    tick();
    press_key(4'd8, ovf_seen);
    check("r_new_digits", 32'(digits_a), 32'h0008);
    check("r_new_count", 32'(count_a), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
